// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter and RAW scoreboard in front of the 32x32 regfile write port.
// Define WB_DBG_PORT_EN to let the debug module arbitrate with top priority.
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            dbg_valid,
  input  logic [AW-1:0]   dbg_rd,
  input  logic [XLEN-1:0] dbg_data,
  output logic            dbg_ready,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     busy
);

  typedef enum logic {
    PREF_ALU = 1'b0,
    PREF_LSU = 1'b1
  } rr_t;

  rr_t             rr, rr_next;
  logic            dbg_grant, alu_grant, lsu_grant, accept;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [31:0]     busy_q, busy_next;

`ifdef WB_DBG_PORT_EN
  assign dbg_grant = dbg_valid;
`else
  logic unused_dbg;
  assign unused_dbg = ^{dbg_valid, dbg_rd, dbg_data};
  assign dbg_grant  = 1'b0;
`endif

  // ALU/LSU round-robin only matters when both request; debug pre-empts both.
  always_comb begin
    alu_grant = 1'b0;
    lsu_grant = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    rr_next   = rr;
    if (!dbg_grant) begin
      if (alu_valid && (!lsu_valid || rr == PREF_ALU)) begin
        alu_grant = 1'b1;
      end else if (lsu_valid) begin
        lsu_grant = 1'b1;
      end
    end
    if (alu_grant) begin
      sel_rd   = alu_rd;
      sel_data = alu_data;
      rr_next  = PREF_LSU;
    end else if (lsu_grant) begin
      sel_rd   = lsu_rd;
      sel_data = lsu_data;
      rr_next  = PREF_ALU;
    end
`ifdef WB_DBG_PORT_EN
    if (dbg_grant) begin
      sel_rd   = dbg_rd;
      sel_data = dbg_data;
    end
`endif
  end

  assign accept    = dbg_grant | alu_grant | lsu_grant;
  assign alu_ready = alu_grant;
  assign lsu_ready = lsu_grant;
  assign dbg_ready = dbg_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= PREF_ALU;
    end else begin
      rr <= rr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= accept && (sel_rd != '0);
      if (accept && (sel_rd != '0)) begin
        rf_rd    <= sel_rd;
        rf_wdata <= sel_data;
      end
    end
  end

  // Set is applied after clear so a fresh issue outlives the retiring write.
  always_comb begin
    busy_next = busy_q;
    if (rf_we) begin
      busy_next[rf_rd] = 1'b0;
    end
    if (iss_valid) begin
      busy_next[iss_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign busy = busy_q;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback arbiter and scoreboard for the 32x32 integer register file, which has one write port. Three writeback sources compete for that port: the ALU, the load/store unit (LSU) and the debug module. The block grants one of them per cycle, registers the winning write onto the regfile write port, and tracks which destination registers have writes in flight so that issue logic can stall on RAW hazards. It sits between the execute/memory stages and the register file's `we`/`rd`/`indata` inputs.

## Interface
- `XLEN`, 32, data width.
- `AW`, 5, register index width (32 registers).
- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — asynchronous active-low reset.
- `alu_valid` input 1 — ALU write request.
- `alu_rd` input AW — ALU destination register.
- `alu_data` input XLEN — ALU write data.
- `alu_ready` output 1 — ALU request accepted this cycle.
- `lsu_valid` input 1 — LSU write request.
- `lsu_rd` input AW — LSU destination register.
- `lsu_data` input XLEN — LSU write data.
- `lsu_ready` output 1 — LSU request accepted this cycle.
- `dbg_valid` input 1 — debug write request.
- `dbg_rd` input AW — debug destination register.
- `dbg_data` input XLEN — debug write data.
- `dbg_ready` output 1 — debug request accepted this cycle.
- `iss_valid` input 1 — an instruction with a destination register issues this cycle.
- `iss_rd` input AW — destination of the issuing instruction.
- `rf_we` output 1 — regfile write enable (registered).
- `rf_rd` output AW — regfile write index (registered).
- `rf_wdata` output XLEN — regfile write data (registered).
- `busy` output 32 — per-register pending-write scoreboard; bit 0 is always 0.

## Operation
- **Handshake.** A transfer occurs on a rising edge where `x_valid & x_ready`.
  - While `x_valid` is high and unaccepted, the requester holds `x_rd` and `x_data` stable.
  - `x_ready` is combinational from the valids; `x_valid` must not depend on `x_ready`.
- **Priority.** Debug beats ALU and LSU. ALU and LSU share the port round-robin.
- **Round-robin pointer `rr`.** Reset value 0, meaning ALU is preferred.
  - A granted ALU transfer sets `rr`=1; a granted LSU transfer sets `rr`=0.
  - Debug grants and idle cycles leave `rr` unchanged.
  - With only one requester valid, that requester is granted regardless of `rr`.
- **Grants.** At most one `x_ready` is high per cycle, and only for a requester whose valid is high.
- **Output register.**
  - On an accepted transfer with rd≠0: `rf_we`←1, `rf_rd`←rd, `rf_wdata`←data.
  - On any other cycle: `rf_we`←0, while `rf_rd` and `rf_wdata` hold.
- **Writes to x0.** Accepted normally (ready asserted) but never produce `rf_we`.
- **Scoreboard.**
  - On `iss_valid` with `iss_rd`≠0: `busy[iss_rd]`←1.
  - On a cycle with `rf_we`=1: `busy[rf_rd]`←0.
  - If set and clear hit the same register in the same cycle, set wins (a newer producer is in flight).
  - `busy[0]` is hard-wired to 0.
  - Debug writes clear `busy` like any other write.
- **Reset (asynchronous, any time, including mid-transfer).**
  - `rf_we`=0, `rf_rd`=0, `rf_wdata`=0, `busy`=0, `rr`=0.
  - An in-flight registered write is dropped.
  - Ready outputs follow the valids combinationally, but no state updates while `rst_n`=0.

## Timing
- **Acceptance.** A request is accepted in the same cycle it is presented if it wins arbitration (zero-cycle acceptance).
- **Write latency.** For a transfer accepted at edge T:
  - `rf_we` is high during cycle T..T+1.
  - The regfile stores the data at edge T+1.
  - `busy` clears at edge T+1.
- **Throughput.** One write per cycle.
- **Contention.** With ALU and LSU continuously valid, grants alternate every cycle.
- **Debug starvation.** A continuously valid debug requester starves ALU and LSU. This is by design: debug only writes while the core is halted.

## Configuration
- **Macro:** `WB_DBG_PORT_EN`.
- **Defined:** the debug requester participates in arbitration with top priority, as described above.
- **Undefined:**
  - `dbg_ready` is tied to 0 and the `dbg_*` inputs are ignored.
  - Arbitration is ALU/LSU round-robin only.
  - Port list is unchanged.

## Test plan
- **Reset state.** Assert `rst_n`=0 mid-stream, with `rf_we`=1 pending → all outputs 0 immediately, `busy`=0. After release, the first ALU+LSU contention grants the ALU.
- **Round-robin.** ALU (rd=3, 0x11111111) and LSU (rd=4, 0x22222222) both held valid for 4 cycles:
  - Readies alternate ALU, LSU, ALU, LSU.
  - `rf_we`/`rf_rd` sequence is 3, 4, 3, 4, each one cycle after its grant.
- **Debug priority.** `dbg_valid` with rd=5, data 0xDEADBEEF, while ALU and LSU are valid:
  - `dbg_ready`=1 and the others are 0.
  - Next cycle `rf_rd`=5, `rf_wdata`=0xDEADBEEF.
  - `rr` is unchanged. With the macro undefined, `dbg_ready` stays 0.
- **x0 write.** ALU rd=0, data 0xFFFFFFFF → `alu_ready`=1, `rf_we` stays 0, `busy`=0.
- **Scoreboard.**
  - `iss_valid` rd=7 → `busy[7]`=1.
  - LSU write to rd=7 → `busy[7]` clears on the edge after `rf_we`.
  - In the same cycle as that `rf_we`, issue rd=7 again → `busy[7]` remains 1.
- **Held request.** LSU valid for 3 cycles while the ALU wins the first → `lsu_rd`/`lsu_data` stay stable, and the LSU is granted in cycle 2 exactly once.
